// File: rtl/hvac_pkg.sv
// Shared types and helpers for the HVAC sequencer: state encoding, fault
// debounce depth and the threshold-flag consistency check.
package hvac_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_VENT  = 3'd1,
        ST_COOL  = 3'd2,
        ST_HEAT  = 3'd3,
        ST_RUNON = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam int unsigned FLT_TICKS = 2;

    // Flags describe one temperature; any pair that cannot hold together marks a sensor fault.
    function automatic logic incons(
        input logic tgt27,
        input logic tgt23,
        input logic tlt23,
        input logic tlt22,
        input logic tgt18,
        input logic tlt15
    );
        return (tgt27 & ~tgt23) | (tgt23 & tlt23) | (tlt22 & ~tlt23) |
               (tgt18 & tlt15)  | (tlt15 & ~tlt22) | (tgt23 & ~tgt18);
    endfunction

endpackage

// File: rtl/hvac_sequencer_if.sv
// Sensor/actuator bundle between the threshold comparators, the sequencer
// and the actuator drivers.
interface hvac_sequencer_if;

    logic       tick;
    logic       enable;
    logic       tgt27;
    logic       tgt23;
    logic       tlt23;
    logic       tlt22;
    logic       tgt18;
    logic       tlt15;
    logic       fan;
    logic       heater;
    logic       ac;
    logic [2:0] state_o;
    logic       ac_locked;
    logic       fault;

    modport master (
        output tick, enable, tgt27, tgt23, tlt23, tlt22, tgt18, tlt15,
        input  fan, heater, ac, state_o, ac_locked, fault
    );

    modport slave (
        input  tick, enable, tgt27, tgt23, tlt23, tlt22, tgt18, tlt15,
        output fan, heater, ac, state_o, ac_locked, fault
    );

endinterface

// File: rtl/hvac_tick_timer.sv
// Loadable down-counter advanced by the timebase strobe; reports when it has
// reached zero. A load on the same edge as a tick takes precedence.
module hvac_tick_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_W'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hvac_sequencer.sv
// Fan/heater/AC sequencer with hysteresis, compressor min-on, AC restart
// lockout, fan run-on and debounced sensor-fault shutdown.
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int unsigned MIN_ON_S  = 60,
    parameter int unsigned MIN_OFF_S = 180,
    parameter int unsigned RUNON_S   = 30,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    hvac_sequencer_if.slave   io
);

    state_t           state;
    state_t           nxt;
    logic [1:0]       flt_cnt;
    logic [1:0]       flt_nxt;
    logic [1:0]       ok_cnt;
    logic [1:0]       ok_nxt;
    logic             incons_w;
    logic             run_zero;
    logic             lock_zero;
    logic             run_load;
    logic             lock_load;
    logic [CNT_W-1:0] run_val;
    logic             fan_r;
    logic             heater_r;
    logic             ac_r;
    logic             fault_r;

    assign incons_w = incons(io.tgt27, io.tgt23, io.tlt23, io.tlt22, io.tgt18, io.tlt15);

    always_comb begin
        flt_nxt = flt_cnt;
        if (io.tick) begin
            if (!incons_w) begin
                flt_nxt = '0;
            end else if (flt_cnt != 2'(FLT_TICKS)) begin
                flt_nxt = flt_cnt + 2'd1;
            end
        end
    end

    // Consecutive clean ticks while in FAULT; held at zero everywhere else.
    always_comb begin
        ok_nxt = '0;
        if (state == ST_FAULT) begin
            ok_nxt = ok_cnt;
            if (io.tick) begin
                if (incons_w) begin
                    ok_nxt = '0;
                end else if (ok_cnt != 2'(FLT_TICKS)) begin
                    ok_nxt = ok_cnt + 2'd1;
                end
            end
        end
    end

    always_comb begin
        nxt = state;
        if ((state != ST_FAULT) && (flt_nxt == 2'(FLT_TICKS))) begin
            nxt = ST_FAULT;
        end else begin
            case (state)
                ST_FAULT: begin
                    if (ok_nxt == 2'(FLT_TICKS)) nxt = ST_OFF;
                end
                ST_OFF: begin
                    if (io.enable) begin
                        if (io.tgt27 && lock_zero) nxt = ST_COOL;
                        else if (io.tlt15)         nxt = ST_HEAT;
                        else if (io.tgt23)         nxt = ST_VENT;
                    end
                end
                ST_VENT: begin
                    if (!io.enable)                 nxt = ST_OFF;
                    else if (io.tgt27 && lock_zero) nxt = ST_COOL;
                    else if (!io.tgt23)             nxt = ST_OFF;
                end
                ST_COOL: begin
                    if (!io.enable || (io.tlt23 && run_zero)) nxt = ST_RUNON;
                end
                ST_HEAT: begin
                    if (!io.enable || (io.tgt18 && run_zero)) nxt = ST_RUNON;
                end
                ST_RUNON: begin
                    if (run_zero) nxt = ST_OFF;
                end
                default: nxt = ST_OFF;
            endcase
        end
    end

    assign run_load  = (nxt != state) &&
                       ((nxt == ST_COOL) || (nxt == ST_HEAT) || (nxt == ST_RUNON));
    assign run_val   = (nxt == ST_RUNON) ? CNT_W'(RUNON_S) : CNT_W'(MIN_ON_S);
    assign lock_load = (state == ST_COOL) && (nxt != ST_COOL);

    hvac_tick_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (0)
    ) u_run_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (io.tick),
        .load     (run_load),
        .load_val (run_val),
        .zero     (run_zero)
    );

    hvac_tick_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (MIN_OFF_S)
    ) u_lock_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (io.tick),
        .load     (lock_load),
        .load_val (CNT_W'(MIN_OFF_S)),
        .zero     (lock_zero)
    );

    // Actuator drives are decoded from the next state so they change with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            flt_cnt  <= '0;
            ok_cnt   <= '0;
            fan_r    <= 1'b0;
            heater_r <= 1'b0;
            ac_r     <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state    <= nxt;
            flt_cnt  <= flt_nxt;
            ok_cnt   <= ok_nxt;
            fan_r    <= (nxt == ST_VENT) || (nxt == ST_COOL) ||
                        (nxt == ST_HEAT) || (nxt == ST_RUNON);
            heater_r <= (nxt == ST_HEAT);
            ac_r     <= (nxt == ST_COOL);
            fault_r  <= (nxt == ST_FAULT);
        end
    end

    assign io.fan       = fan_r;
    assign io.heater    = heater_r;
    assign io.ac        = ac_r;
    assign io.fault     = fault_r;
    assign io.state_o   = state;
    assign io.ac_locked = ~lock_zero;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Scoreboard bench for hvac_sequencer: a temperature-driven reference model
// queues expected outputs per clock, a monitor compares after each edge.
module tb_hvac_sequencer;

    localparam int MIN_ON  = 60;
    localparam int MIN_OFF = 180;
    localparam int RUNON   = 30;

    localparam int S_OFF   = 0;
    localparam int S_VENT  = 1;
    localparam int S_COOL  = 2;
    localparam int S_HEAT  = 3;
    localparam int S_RUNON = 4;
    localparam int S_FAULT = 5;

    typedef struct {
        logic [7:0] v;  // {fan, heater, ac, fault, ac_locked, state[2:0]}
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    int m_st, m_run, m_lock, m_flt, m_ok;

    hvac_sequencer_if io ();

    hvac_sequencer #(
        .MIN_ON_S  (MIN_ON),
        .MIN_OFF_S (MIN_OFF),
        .RUNON_S   (RUNON),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act[7:0], exp[7:0]);
        end
    endtask

    // Flags as seen by ideal comparators at an integer room temperature.
    function automatic logic [5:0] temp_flags(input int t);
        return {t > 27, t > 23, t < 23, t < 22, t > 18, t < 15};
    endfunction

    function automatic bit flags_bad(input logic [5:0] f);
        bit gt27, gt23, lt23, lt22, gt18, lt15;
        {gt27, gt23, lt23, lt22, gt18, lt15} = f;
        return (gt27 && !gt23) || (gt23 && lt23) || (lt22 && !lt23) ||
               (gt18 && lt15) || (lt15 && !lt22) || (gt23 && !gt18);
    endfunction

    task automatic model_reset();
        m_st = S_OFF; m_run = 0; m_lock = MIN_OFF; m_flt = 0; m_ok = 0;
    endtask

    task automatic model_step(input bit tk, input bit en, input logic [5:0] f, output exp_t e);
        bit gt27, gt23, lt23, lt22, gt18, lt15, bad;
        int ns, flt_n, ok_n;
        bit fan, heat, cool;
        {gt27, gt23, lt23, lt22, gt18, lt15} = f;
        bad = flags_bad(f);
        flt_n = !tk ? m_flt : (bad ? ((m_flt + 1 > 2) ? 2 : m_flt + 1) : 0);
        ok_n  = 0;
        if (m_st == S_FAULT)
            ok_n = !tk ? m_ok : (bad ? 0 : ((m_ok + 1 > 2) ? 2 : m_ok + 1));
        ns = m_st;
        if (m_st != S_FAULT && flt_n == 2)               ns = S_FAULT;
        else if (m_st == S_FAULT)                        ns = (ok_n == 2) ? S_OFF : S_FAULT;
        else if (m_st == S_OFF) begin
            if (en && gt27 && m_lock == 0)               ns = S_COOL;
            else if (en && lt15)                         ns = S_HEAT;
            else if (en && gt23)                         ns = S_VENT;
        end else if (m_st == S_VENT) begin
            if (!en)                                     ns = S_OFF;
            else if (gt27 && m_lock == 0)                ns = S_COOL;
            else if (!gt23)                              ns = S_OFF;
        end else if (m_st == S_COOL)                     ns = (!en || (lt23 && m_run == 0)) ? S_RUNON : S_COOL;
        else if (m_st == S_HEAT)                         ns = (!en || (gt18 && m_run == 0)) ? S_RUNON : S_HEAT;
        else if (m_st == S_RUNON)                        ns = (m_run == 0) ? S_OFF : S_RUNON;

        if (ns != m_st && (ns == S_COOL || ns == S_HEAT)) m_run = MIN_ON;
        else if (ns != m_st && ns == S_RUNON)             m_run = RUNON;
        else if (tk && m_run > 0)                          m_run = m_run - 1;
        if (m_st == S_COOL && ns != S_COOL)                m_lock = MIN_OFF;
        else if (tk && m_lock > 0)                         m_lock = m_lock - 1;
        m_st = ns; m_flt = flt_n; m_ok = ok_n;

        fan  = (ns == S_VENT || ns == S_COOL || ns == S_HEAT || ns == S_RUNON);
        heat = (ns == S_HEAT);
        cool = (ns == S_COOL);
        e.v = {fan, heat, cool, ns == S_FAULT, m_lock != 0, 3'(ns)};
    endtask

    task automatic step(input bit en, input logic [5:0] f);
        exp_t e;
        bit tk;
        tk = (cyc % 2) == 0;
        cyc++;
        io.tick = tk;
        io.enable = en;
        {io.tgt27, io.tgt23, io.tlt23, io.tlt22, io.tgt18, io.tlt15} = f;
        model_step(tk, en, f, e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_temp(input int t, input bit en, input int n);
        for (int i = 0; i < n; i++) step(en, temp_flags(t));
    endtask

    task automatic run_until(input logic [5:0] f, input bit en, input int target,
                             input int budget, input string name);
        int k = 0;
        while (int'(io.state_o) != target && k < budget) begin
            step(en, f);
            k++;
        end
        check(name, 32'(io.state_o), 32'(target));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("outputs", {24'd0, io.fan, io.heater, io.ac, io.fault, io.ac_locked, io.state_o},
                  {24'd0, e.v});
            check("heat_cool_interlock", 32'(io.heater & io.ac), 32'd0);
        end
    end

    initial begin
        int t;
        bit en;
        logic [5:0] f;
        exp_t e;

        io.tick = 1'b0; io.enable = 1'b0;
        {io.tgt27, io.tgt23, io.tlt23, io.tlt22, io.tgt18, io.tlt15} = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, io.fan, io.heater, io.ac, io.fault, io.ac_locked, io.state_o},
              32'b0000_1000);
        rst_n = 1'b1;

        // Power-up lockout: VENT first, COOL only once lockout has expired.
        run_temp(30, 1'b1, 20);
        check("powerup_vent", {30'd0, io.fan, io.ac}, 32'b10);
        run_until(temp_flags(30), 1'b1, S_COOL, 500, "powerup_cool");

        // Minimum-on then run-on.
        run_temp(30, 1'b1, 20);
        run_until(temp_flags(22), 1'b1, S_RUNON, 200, "minon_runon");
        run_until(temp_flags(22), 1'b1, S_OFF, 100, "runon_off");

        // Let the lockout from the cooling exit expire.
        run_temp(20, 1'b1, 400);

        // Heating hysteresis.
        run_until(temp_flags(14), 1'b1, S_HEAT, 4, "heat_entry");
        run_temp(16, 1'b1, 40);
        check("heat_hold_16", 32'(io.state_o), S_HEAT);
        run_until(temp_flags(20), 1'b1, S_RUNON, 200, "heat_runon");
        run_until(temp_flags(20), 1'b1, S_OFF, 100, "heat_off");

        // Sensor fault from HEAT and recovery.
        run_until(temp_flags(14), 1'b1, S_HEAT, 4, "heat_entry2");
        run_until(6'b001111, 1'b1, S_FAULT, 12, "fault_entry");
        check("fault_outputs", {29'd0, io.fan, io.heater, io.fault}, 32'b001);
        run_until(temp_flags(16), 1'b1, S_OFF, 12, "fault_exit");
        check("fault_no_lock", 32'(io.ac_locked), 32'd0);

        // Enable drop in COOL.
        run_until(temp_flags(30), 1'b1, S_COOL, 10, "cool_unlocked");
        run_temp(30, 1'b1, 10);
        step(1'b0, temp_flags(30));
        check("endrop_runon", {29'd0, io.ac, io.ac_locked, io.fan}, 32'b011);
        check("endrop_state", 32'(io.state_o), S_RUNON);
        run_temp(30, 1'b1, 100);
        check("relock_vent", 32'(io.state_o), S_VENT);
        run_until(temp_flags(30), 1'b1, S_COOL, 800, "cool_after_lock");

        // Asynchronous reset during RUNON.
        step(1'b0, temp_flags(30));
        run_temp(30, 1'b1, 4);
        check("pre_reset_runon", 32'(io.state_o), S_RUNON);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {24'd0, io.fan, io.heater, io.ac, io.fault, io.ac_locked, io.state_o},
                 32'b0000_1000);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_reset", {29'd0, io.ac_locked, 2'b00} | 32'(io.state_o), 32'b100);

        // Randomized temperature walk with glitches, enable drops and irregular ticks.
        t = 20;
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            t = t + int'($urandom_range(0, 2)) - 1;
            if (t < 10) t = 10;
            if (t > 32) t = 32;
            if ($urandom_range(0, 39) == 0) en = ~en;
            f = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : temp_flags(t);
            io.tick = ($urandom_range(0, 2) == 0);
            io.enable = en;
            {io.tgt27, io.tgt23, io.tlt23, io.tlt22, io.tgt18, io.tlt15} = f;
            model_step(io.tick, en, f, e);
            q.push_back(e);
            @(negedge clk);
        end

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hvac_sequencer.md
Name: hvac_sequencer

Overview:
- Sequences the room's fan, heater and AC from the six temperature-threshold flags: Tgt27, Tgt23, Tlt23, Tlt22, Tgt18 and Tlt15.
- Adds hysteresis, a compressor minimum-on time, AC off-lockout, fan run-on and sensor-fault shutdown.
- Replaces direct combinational decode of the flags. It sits between the threshold comparators and the actuator drivers.

Parameters:
- MIN_ON_S, 60: minimum ticks that COOL or HEAT must remain active before a normal exit.
- MIN_OFF_S, 180: AC restart lockout in ticks after the AC turns off. Also applied after reset.
- RUNON_S, 30: fan run-on ticks after HEAT or COOL ends.
- CNT_W, 8: timer width. The default must be at least clog2(max(MIN_ON_S, MIN_OFF_S, RUNON_S)+1).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset.
- tick, input, 1: single-cycle timebase strobe (1 Hz nominal). Timers advance only on tick.
- enable, input, 1: system enable.
- tgt27, tgt23, tlt23, tlt22, tgt18, tlt15, input, 1 each: threshold flags, already synchronous to clk.
- fan, output, 1: fan drive.
- heater, output, 1: heater drive.
- ac, output, 1: AC compressor drive.
- state_o, output, 3: current state encoding.
- ac_locked, output, 1: AC lockout timer is non-zero.
- fault, output, 1: the block is in the FAULT state.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. clk and rst_n are the clock and reset port names.
- Reset values:
  - state = OFF.
  - fan = heater = ac = 0; fault = 0.
  - run_cnt = 0.
  - lock_cnt = MIN_OFF_S, so ac_locked = 1 after reset. The AC is protected on power-up.
  - flt_cnt = 0.
- Reset asserted mid-operation forces all outputs to 0 immediately. No run-on occurs.
- Update timing:
  - Next-state logic is evaluated every clk.
  - The state register and outputs update on the same edge. Outputs are registered and decoded from the next state.
  - Latency from a flag change to the output change is 1 clk.
- Flag inconsistency:
  - incons = (tgt27 & ~tgt23) | (tgt23 & tlt23) | (tlt22 & ~tlt23) | (tgt18 & tlt15) | (tlt15 & ~tlt22) | (tgt23 & ~tgt18).
- Fault counter flt_cnt (2 bits):
  - On tick with incons = 1: increments, saturating at 2.
  - On tick with incons = 0: clears.
  - Between ticks it holds.
- States and output decode:
  - OFF: all outputs 0.
  - VENT: fan = 1.
  - COOL: fan = 1, ac = 1.
  - HEAT: fan = 1, heater = 1.
  - RUNON: fan = 1.
  - FAULT: all outputs 0, fault = 1.
- Transitions, where a higher line has priority:
  - Any state except FAULT -> FAULT when flt_cnt reaches 2.
  - FAULT -> OFF after 2 consecutive ticks with incons = 0. FAULT never exits directly to a heating or cooling state.
  - enable = 0:
    - COOL or HEAT -> RUNON immediately, ignoring min-on.
    - VENT -> OFF.
    - OFF and RUNON behave normally.
  - From OFF, with enable = 1:
    - tgt27 & ~ac_locked -> COOL.
    - else tlt15 -> HEAT.
    - else tgt23 -> VENT.
  - From VENT:
    - tgt27 & ~ac_locked -> COOL.
    - ~tgt23 -> OFF.
  - From COOL: tlt23 & run_cnt == 0 -> RUNON (cooling hysteresis band 23..27).
  - From HEAT: tgt18 & run_cnt == 0 -> RUNON (heating hysteresis band 15..18).
  - From RUNON: run_cnt == 0 -> OFF. Demand is not re-evaluated until OFF.
- run_cnt:
  - Loads MIN_ON_S on entry to COOL or HEAT.
  - Loads RUNON_S on entry to RUNON.
  - Decrements on tick and saturates at 0.
  - If RUNON_S = 0, RUNON lasts 1 clk.
- lock_cnt:
  - Loads MIN_OFF_S on every exit from COOL, including exits to FAULT.
  - Decrements on tick while non-zero.
  - A tick arriving on the load edge is ignored, because the load wins.
- Invariant: heater and ac are never 1 in the same cycle.

Decomposition:
- Package hvac_pkg holds:
  - state enum: OFF = 0, VENT = 1, COOL = 2, HEAT = 3, RUNON = 4, FAULT = 5.
  - FLT_TICKS = 2.
  - incons function.
- Sub-module hvac_tick_timer: a loadable down-counter with load, load_val, tick and zero outputs. It is instantiated twice, once for run_cnt and once for lock_cnt.

Test Plan:
- Power-up lockout: reset, then tgt27 = tgt23 = tgt18 = 1 -> enters VENT (fan = 1, ac = 0); COOL is entered on the clk after the 180th tick; ac = 1.
- Minimum-on: in COOL, set tlt23 = 1 and tgt23 = 0 after 10 ticks -> ac stays 1 until 60 ticks from COOL entry; then RUNON for 30 ticks with fan = 1; then OFF with all outputs 0.
- Heating hysteresis: tlt15 = tlt22 = tlt23 = 1 -> HEAT with heater = 1 after 1 clk; clearing tlt15 (16 degrees) keeps HEAT; after min-on elapses, tgt18 = 1 gives RUNON.
- Fault: apply tgt18 = tlt15 = 1 in HEAT across 2 ticks -> FAULT with heater = fan = 0 and fault = 1; restore consistent flags for 2 ticks -> OFF; ac_locked stays 0 because the block never entered COOL.
- Enable drop: enable = 0 in COOL after 5 ticks -> RUNON on the next clk with ac = 0; lock_cnt reloads to 180; re-enabling with tgt27 = 1 does not allow COOL until lockout expires.
- Reset mid-RUNON: assert rst_n = 0 -> fan drops asynchronously; after release, ac_locked = 1 and state_o = 0.
